// File: rtl/ak6502_pkg.sv
// Shared constants and types for the AK6502 core front-end blocks.
// Holds default parameter values for the interrupt/reset front-end.
// Also defines the reset-sequencer state encoding.
package ak6502_pkg;

  localparam int SYNC_STAGES_DEF = 2;
  localparam int FILTER_LEN_DEF  = 2;
  localparam int RST_HOLD_DEF    = 8;

  // Core reset sequencer: HOLD while counting clk_en ticks, RUN afterwards.
  typedef enum logic {
    HOLD = 1'b0,
    RUN  = 1'b1
  } rst_state_t;

endpackage

// File: rtl/pin_filter.sv
// Synchroniser plus deglitch filter for one active-low asynchronous pin.
// Latency: SYNC_STAGES clk edges, then FILTER_LEN clk_en ticks to accept a level change.
// No backpressure; the filter simply holds its state on cycles with clk_en=0.
module pin_filter
  import ak6502_pkg::*;
#(
  parameter int SYNC_STAGES = SYNC_STAGES_DEF,
  parameter int FILTER_LEN  = FILTER_LEN_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic clk_en,
  input  logic pin,
  output logic filt,
  output logic filt_next
);

  localparam int CW = $clog2(FILTER_LEN + 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   synced;
  logic [CW-1:0]          cnt;
  logic [CW-1:0]          cnt_next;

  assign synced = sync_q[SYNC_STAGES-1];

  // Synchroniser chain runs on every clk edge, independent of clk_en; idles high.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], pin};
    end
  end

  // Count consecutive differing samples; flip the level on the FILTER_LEN-th one.
  always_comb begin
    filt_next = filt;
    cnt_next  = cnt;
    if (clk_en) begin
      if (synced == filt) begin
        cnt_next = '0;
      end else if (cnt == CW'(FILTER_LEN - 1)) begin
        filt_next = ~filt;
        cnt_next  = '0;
      end else begin
        cnt_next = cnt + CW'(1);
      end
    end
  end

  // Filter state registers; the filtered level idles high like the pin.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      filt <= 1'b1;
      cnt  <= '0;
    end else begin
      filt <= filt_next;
      cnt  <= cnt_next;
    end
  end

endmodule

// File: rtl/int_ctrl.sv
// Interrupt/reset front-end for the AK6502 control unit: filtered IRQ level, latched NMI, core reset sequencing.
// Latency: pin to irq_n/nmi_n is SYNC_STAGES clk edges + FILTER_LEN clk_en ticks; core_rst_n rises RST_HOLD ticks after rst.
// No backpressure; a pending NMI is held until nmi_ack is sampled on a clk_en cycle.
module int_ctrl
  import ak6502_pkg::*;
#(
  parameter int SYNC_STAGES = SYNC_STAGES_DEF,
  parameter int FILTER_LEN  = FILTER_LEN_DEF,
  parameter int RST_HOLD    = RST_HOLD_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic clk_en,
  input  logic irq_pin_n,
  input  logic nmi_pin_n,
  input  logic nmi_ack,
  output logic core_rst_n,
  output logic irq_n,
  output logic nmi_n,
  output logic nmi_pending
);

  localparam int HW = $clog2(RST_HOLD + 1);

  rst_state_t    state;
  logic [HW-1:0] hold_cnt;

  // IRQ is consumed as a level from the filter's next value; its registered copy is not needed.
  logic unused_irq_filt;
  logic irq_filt_next;
  logic nmi_filt;
  logic nmi_filt_next;

  logic nmi_edge;
  logic pend_next;

  pin_filter #(
    .SYNC_STAGES(SYNC_STAGES),
    .FILTER_LEN (FILTER_LEN)
  ) u_irq_filter (
    .clk      (clk),
    .rst      (rst),
    .clk_en   (clk_en),
    .pin      (irq_pin_n),
    .filt     (unused_irq_filt),
    .filt_next(irq_filt_next)
  );

  pin_filter #(
    .SYNC_STAGES(SYNC_STAGES),
    .FILTER_LEN (FILTER_LEN)
  ) u_nmi_filter (
    .clk      (clk),
    .rst      (rst),
    .clk_en   (clk_en),
    .pin      (nmi_pin_n),
    .filt     (nmi_filt),
    .filt_next(nmi_filt_next)
  );

  // Reset sequencer: count RST_HOLD clk_en ticks in HOLD, release the core on the last one.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= HOLD;
      hold_cnt   <= '0;
      core_rst_n <= 1'b0;
    end else begin
      case (state)
        HOLD: begin
          if (clk_en) begin
            if (hold_cnt == HW'(RST_HOLD - 1)) begin
              state      <= RUN;
              hold_cnt   <= '0;
              core_rst_n <= 1'b1;
            end else begin
              hold_cnt <= hold_cnt + HW'(1);
            end
          end
        end
        RUN: begin
          core_rst_n <= 1'b1;
        end
        default: begin
          state      <= HOLD;
          hold_cnt   <= '0;
          core_rst_n <= 1'b0;
        end
      endcase
    end
  end

  // A filtered 1->0 transition only counts once the core is running; a new edge beats a same-cycle ack.
  always_comb begin
    nmi_edge  = (state == RUN) && nmi_filt && !nmi_filt_next;
    pend_next = nmi_pending;
    if (nmi_edge) begin
      pend_next = 1'b1;
    end else if (clk_en && nmi_ack) begin
      pend_next = 1'b0;
    end
  end

  // Registered interrupt outputs; IRQ is forced inactive while the core is held in reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      irq_n       <= 1'b1;
      nmi_n       <= 1'b1;
      nmi_pending <= 1'b0;
    end else begin
      irq_n       <= irq_filt_next | (state == HOLD);
      nmi_n       <= ~pend_next;
      nmi_pending <= pend_next;
    end
  end

endmodule

// File: tb/tb_int_ctrl.sv
// Directed bench for int_ctrl with default parameters.
// Inputs are driven and outputs sampled 1 time unit after each rising clk edge.
// Expected values are hand-derived from the edge/tick timing of the block.
module tb_int_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic clk_en = 1'b1;
  logic irq_pin_n = 1'b1;
  logic nmi_pin_n = 1'b0;
  logic nmi_ack = 1'b0;
  logic core_rst_n;
  logic irq_n;
  logic nmi_n;
  logic nmi_pending;

  int checks = 0;
  int failures = 0;
  bit gated = 1'b0;
  int phase = 0;
  bit seen_low;

  int_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .clk_en     (clk_en),
    .irq_pin_n  (irq_pin_n),
    .nmi_pin_n  (nmi_pin_n),
    .nmi_ack    (nmi_ack),
    .core_rst_n (core_rst_n),
    .irq_n      (irq_n),
    .nmi_n      (nmi_n),
    .nmi_pending(nmi_pending)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // One clk edge; in gated mode clk_en is high on every third edge.
  task automatic tick();
    @(posedge clk);
    #1;
    if (gated) begin
      phase  = (phase + 1) % 3;
      clk_en = (phase == 0);
    end
  endtask

  task automatic ticks(input int n);
    repeat (n) tick();
  endtask

  initial begin
    // Reset state with NMI pin already low.
    ticks(3);
    chk("rst_core_rst_n", core_rst_n, 1'b0);
    chk("rst_irq_n", irq_n, 1'b1);
    chk("rst_nmi_n", nmi_n, 1'b1);
    chk("rst_nmi_pending", nmi_pending, 1'b0);

    // Release: core_rst_n low for 7 edges, high on the 8th; NMI held low is ignored.
    rst = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      tick();
      chk($sformatf("hold_core_rst_n_%0d", i), core_rst_n, (i == 8));
      chk($sformatf("hold_irq_n_%0d", i), irq_n, 1'b1);
      chk($sformatf("hold_nmi_n_%0d", i), nmi_n, 1'b1);
    end

    // NMI: raise, then fall -> nmi_n low on the 4th edge.
    nmi_pin_n = 1'b1;
    ticks(6);
    chk("nmi_after_raise", nmi_n, 1'b1);
    nmi_pin_n = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      tick();
      chk($sformatf("nmi_fall_%0d", i), nmi_n, (i < 4));
    end
    chk("nmi_pending_set", nmi_pending, 1'b1);
    ticks(5);
    chk("nmi_held", nmi_n, 1'b0);
    nmi_ack = 1'b1;
    tick();
    nmi_ack = 1'b0;
    chk("nmi_ack_clear", nmi_n, 1'b1);
    chk("nmi_ack_pending", nmi_pending, 1'b0);
    ticks(6);
    chk("nmi_no_second", nmi_n, 1'b1);

    // IRQ 1-cycle glitch is rejected.
    irq_pin_n = 1'b0;
    tick();
    irq_pin_n = 1'b1;
    seen_low = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (!irq_n) seen_low = 1'b1;
    end
    chk("irq_glitch_rejected", seen_low, 1'b0);

    // IRQ 10-cycle pulse: low 4 edges after fall, high 4 edges after rise.
    irq_pin_n = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      tick();
      chk($sformatf("irq_fall_%0d", i), irq_n, (i < 4));
    end
    irq_pin_n = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      tick();
      chk($sformatf("irq_rise_%0d", i), irq_n, (i >= 4));
    end

    // New NMI edge with ack on the same edge: the NMI wins.
    nmi_pin_n = 1'b1;
    ticks(6);
    nmi_pin_n = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      tick();
      chk($sformatf("coll_pre_%0d", i), nmi_n, 1'b1);
    end
    nmi_ack = 1'b1;
    tick();
    nmi_ack = 1'b0;
    chk("coll_nmi_n", nmi_n, 1'b0);
    chk("coll_pending", nmi_pending, 1'b1);
    tick();
    chk("coll_nmi_n_after", nmi_n, 1'b0);

    // Asynchronous reset pulse while NMI pending: outputs return immediately.
    rst = 1'b1;
    #1;
    chk("arst_nmi_n", nmi_n, 1'b1);
    chk("arst_nmi_pending", nmi_pending, 1'b0);
    chk("arst_core_rst_n", core_rst_n, 1'b0);
    chk("arst_irq_n", irq_n, 1'b1);
    ticks(2);
    rst = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      tick();
      chk($sformatf("rehold_core_rst_n_%0d", i), core_rst_n, (i == 8));
      chk($sformatf("rehold_nmi_n_%0d", i), nmi_n, 1'b1);
    end

    // Gated clk_en 1-in-3: first tick on edge 3, so core_rst_n rises on edge 24.
    rst = 1'b1;
    tick();
    gated  = 1'b1;
    phase  = 1;
    clk_en = 1'b0;
    rst    = 1'b0;
    for (int i = 1; i <= 24; i++) begin
      tick();
      chk($sformatf("gated_core_rst_n_%0d", i), core_rst_n, (i == 24));
      chk($sformatf("gated_irq_n_%0d", i), irq_n, 1'b1);
    end

    // 3-cycle IRQ pulse spans one clk_en tick -> rejected.
    irq_pin_n = 1'b0;
    ticks(3);
    irq_pin_n = 1'b1;
    seen_low = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (!irq_n) seen_low = 1'b1;
    end
    chk("gated_short_rejected", seen_low, 1'b0);

    // 9-cycle IRQ pulse spans three ticks -> accepted, then released.
    irq_pin_n = 1'b0;
    seen_low = 1'b0;
    for (int i = 0; i < 9; i++) begin
      tick();
      if (!irq_n) seen_low = 1'b1;
    end
    irq_pin_n = 1'b1;
    for (int i = 0; i < 9; i++) begin
      tick();
      if (!irq_n) seen_low = 1'b1;
    end
    chk("gated_long_accepted", seen_low, 1'b1);
    ticks(15);
    chk("gated_long_released", irq_n, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
